// File: rtl/debounce_sync.sv
// Conditions one asynchronous, bouncing input into a synchronized, debounced
// level with registered rise/fall pulses and a saturating glitch counter.
module debounce_sync #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       din,
   output logic       dout,
   output logic       rise_pulse,
   output logic       fall_pulse,
   output logic       busy,
   output logic [7:0] glitch_count
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [0:0] {
      ST_STABLE   = 1'b0,
      ST_COUNTING = 1'b1
   } state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   s_s;
   state_t                 state_r, state_s;
   logic [CNT_W-1:0]       cnt_r, cnt_s;
   logic                   dout_r, dout_s;
   logic                   rise_r, rise_s;
   logic                   fall_r, fall_s;
   logic                   busy_r;
   logic [7:0]             glitch_r, glitch_s;

   assign s_s          = sync_r[SYNC_STAGES-1];
   assign dout         = dout_r;
   assign rise_pulse   = rise_r;
   assign fall_pulse   = fall_r;
   assign busy         = busy_r;
   assign glitch_count = glitch_r;

   // Metastability synchronizer chain; shifts regardless of enable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      end
   end

   // Next-state and next-output logic for the debounce FSM.
   always_comb begin
      state_s  = state_r;
      cnt_s    = '0;
      dout_s   = dout_r;
      rise_s   = 1'b0;
      fall_s   = 1'b0;
      glitch_s = glitch_r;
      case (state_r)
         ST_STABLE: begin
            if (enable && (s_s != dout_r)) begin
               state_s = ST_COUNTING;
               cnt_s   = CNT_W'(1);
            end else begin
               state_s = ST_STABLE;
            end
         end
         ST_COUNTING: begin
            // Abort beats glitch, and glitch beats terminal count.
            if (!enable) begin
               state_s = ST_STABLE;
            end else if (s_s == dout_r) begin
               state_s  = ST_STABLE;
               glitch_s = sat_inc8(glitch_r);
            end else if (cnt_r == CNT_LAST) begin
               state_s = ST_STABLE;
               dout_s  = s_s;
               rise_s  = s_s;
               fall_s  = ~s_s;
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         default: begin
            state_s = ST_STABLE;
         end
      endcase
   end

   // FSM state, counter and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r  <= ST_STABLE;
         cnt_r    <= '0;
         dout_r   <= 1'b0;
         rise_r   <= 1'b0;
         fall_r   <= 1'b0;
         busy_r   <= 1'b0;
         glitch_r <= 8'd0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         dout_r   <= dout_s;
         rise_r   <= rise_s;
         fall_r   <= fall_s;
         busy_r   <= (state_s == ST_COUNTING);
         glitch_r <= glitch_s;
      end
   end

endmodule

// File: tb/tb_debounce_sync.sv
// Directed and randomized checks of debounce_sync with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4 against hand-computed values and a cycle model.
module tb_debounce_sync;

   localparam int SS = 2;
   localparam int DC = 4;

   logic       clk;
   logic       reset_n;
   logic       enable;
   logic       din;
   logic       dout;
   logic       rise_pulse;
   logic       fall_pulse;
   logic       busy;
   logic [7:0] glitch_count;

   int checks;
   int failures;

   // Reference model state: stable-run length k replaces an explicit FSM.
   logic [SS-1:0] m_sync;
   int            m_k;
   logic          m_dout;
   logic          m_rise;
   logic          m_fall;
   logic [7:0]    m_glitch;

   debounce_sync #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .din          (din),
      .dout         (dout),
      .rise_pulse   (rise_pulse),
      .fall_pulse   (fall_pulse),
      .busy         (busy),
      .glitch_count (glitch_count)
   );

   // 10 ns system clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_sync   = '0;
      m_k      = 0;
      m_dout   = 1'b0;
      m_rise   = 1'b0;
      m_fall   = 1'b0;
      m_glitch = 8'd0;
   endtask

   task automatic model_edge();
      logic ms;
      if (!reset_n) begin
         model_reset();
      end else begin
         ms     = m_sync[SS-1];
         m_rise = 1'b0;
         m_fall = 1'b0;
         if (!enable) begin
            m_k = 0;
         end else if (ms == m_dout) begin
            if (m_k > 0 && m_glitch != 8'd255) m_glitch = m_glitch + 8'd1;
            m_k = 0;
         end else begin
            m_k++;
            if (m_k == DC) begin
               m_dout = ms;
               m_rise = ms;
               m_fall = ~ms;
               m_k    = 0;
            end
         end
         m_sync = {m_sync[SS-2:0], din};
      end
   endtask

   // Advance n rising edges; compare every output with the model 1 ns later.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge();
         #1;
         check_eq("m_dout", 32'(dout), 32'(m_dout));
         check_eq("m_rise", 32'(rise_pulse), 32'(m_rise));
         check_eq("m_fall", 32'(fall_pulse), 32'(m_fall));
         check_eq("m_busy", 32'(busy), 32'(m_k > 0));
         check_eq("m_glitch", 32'(glitch_count), 32'(m_glitch));
         check_eq("pulse_excl", 32'(rise_pulse & fall_pulse), 32'd0);
      end
   endtask

   initial begin
      int remain;
      checks   = 0;
      failures = 0;
      model_reset();

      // Reset held with din=1: everything zero.
      reset_n = 1'b0;
      enable  = 1'b1;
      din     = 1'b1;
      #22;
      check_eq("rst_dout", 32'(dout), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_pulses", 32'({rise_pulse, fall_pulse}), 32'd0);
      check_eq("rst_glitch", 32'(glitch_count), 32'd0);
      din     = 1'b0;
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check_eq("idle_outs", 32'({dout, rise_pulse, fall_pulse, busy}), 32'd0);
      end

      // Clean rise: busy after edge 3, dout/rise after edge 6.
      din = 1'b1;
      tick(2);
      check_eq("rise_busy_e2", 32'(busy), 32'd0);
      tick(1);
      check_eq("rise_busy_e3", 32'(busy), 32'd1);
      tick(2);
      check_eq("rise_dout_e5", 32'(dout), 32'd0);
      tick(1);
      check_eq("rise_dout_e6", 32'(dout), 32'd1);
      check_eq("rise_pulse_e6", 32'(rise_pulse), 32'd1);
      check_eq("rise_fall_e6", 32'(fall_pulse), 32'd0);
      tick(1);
      check_eq("rise_pulse_e7", 32'(rise_pulse), 32'd0);
      check_eq("rise_dout_e7", 32'(dout), 32'd1);

      // Clean fall mirrors the rise timing.
      din = 1'b0;
      tick(3);
      check_eq("fall_busy_e3", 32'(busy), 32'd1);
      tick(2);
      check_eq("fall_dout_e5", 32'(dout), 32'd1);
      tick(1);
      check_eq("fall_dout_e6", 32'(dout), 32'd0);
      check_eq("fall_pulse_e6", 32'(fall_pulse), 32'd1);
      tick(1);
      check_eq("fall_pulse_e7", 32'(fall_pulse), 32'd0);
      check_eq("clean_glitch", 32'(glitch_count), 32'd0);

      // Two-cycle bounce is rejected and counted.
      din = 1'b1;
      tick(2);
      din = 1'b0;
      tick(6);
      check_eq("bounce_dout", 32'(dout), 32'd0);
      check_eq("bounce_busy", 32'(busy), 32'd0);
      check_eq("bounce_glitch", 32'(glitch_count), 32'd1);

      // Enable abort at edge 4, then restart from scratch on re-enable.
      din = 1'b1;
      tick(3);
      enable = 1'b0;
      tick(1);
      check_eq("abort_busy", 32'(busy), 32'd0);
      tick(4);
      check_eq("abort_dout", 32'(dout), 32'd0);
      check_eq("abort_glitch", 32'(glitch_count), 32'd1);
      enable = 1'b1;
      tick(3);
      check_eq("reen_dout_e3", 32'(dout), 32'd0);
      tick(1);
      check_eq("reen_dout_e4", 32'(dout), 32'd1);
      check_eq("reen_rise_e4", 32'(rise_pulse), 32'd1);
      din = 1'b0;
      tick(8);

      // Asynchronous reset in the middle of a count.
      din = 1'b1;
      tick(4);
      check_eq("mid_busy_pre", 32'(busy), 32'd1);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_eq("arst_busy", 32'(busy), 32'd0);
      check_eq("arst_dout", 32'(dout), 32'd0);
      check_eq("arst_glitch", 32'(glitch_count), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      tick(5);
      check_eq("arst_lat_e5", 32'(dout), 32'd0);
      tick(1);
      check_eq("arst_lat_e6", 32'(dout), 32'd1);
      din = 1'b0;
      tick(8);

      // 300 bounces saturate the glitch counter.
      for (int r = 0; r < 300; r++) begin
         din = 1'b1;
         tick(2);
         din = 1'b0;
         tick(6);
      end
      check_eq("sat_glitch", 32'(glitch_count), 32'd255);
      check_eq("sat_dout", 32'(dout), 32'd0);

      // Random toggling against the model.
      remain = 1;
      for (int c = 0; c < 10000; c++) begin
         remain--;
         if (remain == 0) begin
            din    = ~din;
            remain = $urandom_range(10, 1);
         end
         enable = ($urandom_range(19, 0) != 0);
         tick(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
Conditions one asynchronous, possibly bouncing input (button, switch, external strobe) into a clean, clock-domain-safe level and edge pulses. Sits directly upstream of the team's registered single-bit stages and control logic. Those stages consume `dout`, `rise_pulse` or `fall_pulse` as their data input. Chain: multi-stage synchronizer, then a debounce FSM with a stability counter, then edge detection and a saturating glitch counter.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops; legal range is ≥2.
DEBOUNCE_CYCLES, 16, consecutive synchronized cycles the new level must hold before `dout` changes; legal range is ≥2.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset_n  input  1  asynchronous active-low reset.
enable  input  1  debounce enable; when low, no new transition is accepted.
din  input  1  raw asynchronous input.
dout  output  1  debounced, synchronized level.
rise_pulse  output  1  one-cycle pulse on a 0→1 transition of `dout`.
fall_pulse  output  1  one-cycle pulse on a 1→0 transition of `dout`.
busy  output  1  high while the FSM is in COUNTING.
glitch_count  output  8  saturating count of rejected bounces.

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately, including mid-count):
  - sync chain = 0, FSM = STABLE, counter = 0.
  - dout = 0, rise_pulse = 0, fall_pulse = 0, busy = 0, glitch_count = 0.
- Synchronizer:
  - `din` shifts through SYNC_STAGES flops every clock, regardless of `enable`.
  - `s` is the last stage. Only `s` is used downstream; no logic reads `din` directly.
- Counter width is ≥ clog2(DEBOUNCE_CYCLES+1). All internal state and outputs are registered.
- FSM, state STABLE:
  - If enable=1 and s≠dout: go to COUNTING, cnt=1, busy=1.
  - Otherwise remain, cnt=0.
- FSM, state COUNTING, evaluated in priority order:
  1. enable=0: return to STABLE, cnt=0; glitch_count unchanged (abort, not a glitch).
  2. s==dout: return to STABLE, cnt=0, glitch_count+1 saturating at 255.
  3. cnt==DEBOUNCE_CYCLES-1: dout←s, return to STABLE, cnt=0. In the same edge, rise_pulse←s (for 0→1) or fall_pulse←~s (for 1→0).
  4. Else: cnt+1.
- Output timing:
  - busy = (state==COUNTING), registered.
  - Pulses are high exactly in the first cycle `dout` shows its new value, for one cycle only. They are never both high.
- Latency: a `din` change held stable, with enable=1, changes `dout` at the SYNC_STAGES+DEBOUNCE_CYCLES-th rising edge after the change. Defaults: 18 edges.
- A change shorter than DEBOUNCE_CYCLES synchronized cycles never reaches `dout`.
- Simultaneous events:
  - Glitch return and counter terminal count cannot coincide; the s==dout check takes priority.
  - Glitch increment at 255 holds 255.
- Re-enable: when enable rises with s≠dout, counting restarts from cnt=1 on that edge. Partial progress from before the abort is never reused.

Test Plan:
Bench parameters SYNC_STAGES=2, DEBOUNCE_CYCLES=4; edges are counted from the first edge after `din` changes.
- Reset: hold reset_n=0 with din=1 → all outputs 0. Release with din=0 → outputs stay 0 for 20 cycles.
- Clean rise then fall:
  - din 0→1 held → busy high after edge 3, dout=1 and rise_pulse=1 after edge 6, rise_pulse=0 after edge 7.
  - din 1→0 → fall_pulse mirrors this timing.
  - glitch_count=0 throughout.
- Bounce: din=1 for 2 cycles, then 0 → dout stays 0, no pulses, busy drops, glitch_count=1. Repeat 300 times → glitch_count=255.
- Enable abort: din 0→1, drop enable at edge 4, hold low 5 cycles → dout=0, glitch_count unchanged. Raise enable → dout=1 and rise_pulse at the 4th edge counting the re-enable edge.
- Asynchronous reset mid-count: assert reset_n=0 between edges during COUNTING → busy, dout and counters 0 immediately, without waiting for a clock edge. After release with din held 1 → full 6-edge latency to dout=1.
- Random din toggling (period 1–10 cycles, 10k cycles) against a reference model → dout, pulses and glitch_count match every cycle; rise_pulse and fall_pulse never both high.
